// File: rtl/pe_result_drain.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pe_result_drain                                            |
// | Description : Reader end of a PE output stream. Sums KERNEL_SIZE         |
// |               consecutive unsigned products into one window result,      |
// |               buffers results in a small FIFO and drains them on a       |
// |               valid/ready handshake.                                     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module pe_result_drain #(
   parameter int TOTAL_WIDTH = 16,
   parameter int KERNEL_SIZE = 9,   // >= 2
   parameter int ACC_WIDTH   = 20,  // >= TOTAL_WIDTH + clog2(KERNEL_SIZE)
   parameter int FIFO_DEPTH  = 4    // power of two, >= 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [TOTAL_WIDTH-1:0] in_data,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   clear,
   output logic [ACC_WIDTH-1:0]   out_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   busy
);

   localparam int CNT_W = $clog2(KERNEL_SIZE);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] C_LAST  = CNT_W'(KERNEL_SIZE - 1);
   localparam logic [PTR_W:0]   C_DEPTH = (PTR_W + 1)'(FIFO_DEPTH);

   // State encoding is relied upon by external observers: IDLE=0, ACCUM=1, STALL=2.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_STALL = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [ACC_WIDTH-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]       count_q, count_d;
   logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]         occ_q, occ_d;
   logic [ACC_WIDTH-1:0]   mem_q [FIFO_DEPTH];

   logic                   accept;
   logic                   last_sample;
   logic                   push;
   logic                   pop;
   logic [ACC_WIDTH-1:0]   sum;

   // Outputs come straight from registered state; out_ready never reaches in_ready.
   assign in_ready  = (state_q != ST_STALL);
   assign busy      = (state_q != ST_IDLE);
   assign out_valid = (occ_q != '0);
   assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;

   // Next-state computation for accumulator, window counter, FIFO pointers and FSM.
   always_comb begin
      accept      = in_valid && in_ready;
      last_sample = (count_q == C_LAST);
      sum         = acc_q + ACC_WIDTH'(in_data);
      // clear discards the presented sample, so it can never complete a window
      push        = accept && last_sample && !clear;
      pop         = out_valid && out_ready;

      acc_d    = acc_q;
      count_d  = count_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;

      if (clear) begin
         acc_d   = '0;
         count_d = '0;
      end else if (accept) begin
         if (last_sample) begin
            acc_d   = '0;
            count_d = '0;
         end else begin
            acc_d   = sum;
            count_d = count_q + 1'b1;
         end
      end

      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

      case ({push, pop})
         2'b10:   occ_d = occ_q + 1'b1;
         2'b01:   occ_d = occ_q - 1'b1;
         default: occ_d = occ_q;
      endcase

      // State mirrors the next counter/occupancy so in_ready and busy stay registered.
      if (count_d == '0)
         state_d = ST_IDLE;
      else if ((count_d == C_LAST) && (occ_d == C_DEPTH))
         state_d = ST_STALL;
      else
         state_d = ST_ACCUM;
   end

   // Control state with asynchronous reset; reset drops all partial and buffered results.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         acc_q    <= '0;
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
      end
   end

   // Result storage; contents are only visible while occupancy marks them valid.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= sum;
   end

endmodule
`default_nettype wire

// File: tb/tb_pe_result_drain.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_pe_result_drain                                         |
// | Description : Directed self-checking bench for pe_result_drain with an   |
// |               expected-result queue drained by an output monitor.        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_pe_result_drain;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic        clear;
   logic [19:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic        busy;

   int          checks   = 0;
   int          failures = 0;
   logic [31:0] exp_q[$];

   pe_result_drain #(
      .TOTAL_WIDTH (16),
      .KERNEL_SIZE (9),
      .ACC_WIDTH   (20),
      .FIFO_DEPTH  (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .clear     (clear),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // One comparison point: counts every check and reports mismatches.
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer one sample and hold it until accepted, within a cycle budget.
   task automatic send(input logic [15:0] d);
      bit ok = 0;
      in_data  = d;
      in_valid = 1'b1;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         ok = in_ready;
         step();
      end
      chk("send_accept_timeout", 32'(ok), 1);
   endtask

   // Wait for the scoreboard to empty, within a cycle budget.
   task automatic drain();
      for (int i = 0; i < 60 && exp_q.size() != 0; i++) step();
      chk("drain_queue_empty", 32'(exp_q.size()), 0);
   endtask

   // Output monitor: the handshake seen mid-cycle is the one taken at the next edge.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         chk("unexpected_output", 32'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0) chk("out_data", 32'(out_data), exp_q.pop_front());
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; in_data = '0; in_valid = 1'b0; clear = 1'b0; out_ready = 1'b0;

      // Reset state
      step(); step();
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_busy",      32'(busy),      0);
      chk("rst_in_ready",  32'(in_ready),  1);
      rst = 1'b0;
      step();
      chk("post_rst_out_valid", 32'(out_valid), 0);
      chk("post_rst_in_ready",  32'(in_ready),  1);

      // Single window 1..9 back-to-back, result visible for exactly one cycle
      out_ready = 1'b1;
      exp_q.push_back(45);
      for (int i = 1; i <= 9; i++) begin
         chk("win1_in_ready", 32'(in_ready), 1);
         in_data  = 16'(i);
         in_valid = 1'b1;
         step();
         chk("win1_busy",      32'(busy),      32'(i != 9));
         chk("win1_out_valid", 32'(out_valid), 32'(i == 9));
      end
      in_valid = 1'b0;
      step();
      chk("win1_one_cycle", 32'(out_valid), 0);
      drain();

      // Max product values, no wrap at 20 bits
      exp_q.push_back(585225);
      for (int i = 0; i < 9; i++) send(16'd65025);
      in_valid = 1'b0;
      drain();

      // Backpressure: five windows of 1s against a four-entry FIFO
      out_ready = 1'b0;
      for (int w = 0; w < 5; w++) exp_q.push_back(9);
      in_data  = 16'd1;
      in_valid = 1'b1;
      repeat (44) step();
      repeat (3) step();
      chk("bp_in_ready_stalled", 32'(in_ready),      0);
      chk("bp_state_stall",      32'(dut.state_q),   2);
      chk("bp_busy",             32'(busy),          1);
      chk("bp_out_valid",        32'(out_valid),     1);
      chk("bp_head",             32'(out_data),      9);
      out_ready = 1'b1;
      step();
      chk("bp_in_ready_after_pop", 32'(in_ready), 1);
      step();
      in_valid = 1'b0;
      chk("bp_idle_after_last", 32'(busy), 0);
      drain();

      // Clear mid-window discards partial sum and the sample presented with it
      for (int i = 0; i < 4; i++) send(16'd7);
      chk("clr_busy_before", 32'(busy), 1);
      clear    = 1'b1;
      in_data  = 16'd7;
      in_valid = 1'b1;
      step();
      clear    = 1'b0;
      in_valid = 1'b0;
      chk("clr_busy_after",  32'(busy),      0);
      chk("clr_no_output",   32'(out_valid), 0);
      exp_q.push_back(18);
      for (int i = 0; i < 9; i++) send(16'd2);
      in_valid = 1'b0;
      drain();

      // Reset with two buffered results and a partial window
      out_ready = 1'b0;
      for (int i = 0; i < 21; i++) send(16'd1);
      in_valid = 1'b0;
      step();
      chk("pre_rst_out_valid", 32'(out_valid), 1);
      chk("pre_rst_busy",      32'(busy),      1);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_out_valid", 32'(out_valid), 0);
      chk("async_rst_busy",      32'(busy),      0);
      chk("async_rst_in_ready",  32'(in_ready),  1);
      step(); step();
      rst = 1'b0;
      out_ready = 1'b1;
      exp_q.push_back(27);
      for (int i = 0; i < 9; i++) send(16'd3);
      in_valid = 1'b0;
      drain();
      repeat (5) step();
      chk("final_out_valid", 32'(out_valid), 0);
      chk("final_busy",      32'(busy),      0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pe_result_drain.md
Name: pe_result_drain

Overview:
- Consumer (reader) end of the PE output stream: takes the product word leaving a `pe` cell and sums KERNEL_SIZE consecutive products into one window result.
- Buffers completed results in a small FIFO and presents them downstream on a valid/ready handshake.
- Sits between the PE column output and the feature-map writeback logic.

Parameters:
- TOTAL_WIDTH, 16, width of one PE product word (DATA_WIDTH + WEIGHT_WIDTH).
- KERNEL_SIZE, 9, products summed per window result (>= 2).
- ACC_WIDTH, 20, accumulator/result width; must be >= TOTAL_WIDTH + clog2(KERNEL_SIZE).
- FIFO_DEPTH, 4, result FIFO entries (power of two).

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  TOTAL_WIDTH  PE product (pe_output), unsigned.
- in_valid  input  1  in_data valid this cycle.
- in_ready  output  1  block accepts in_data this cycle.
- clear  input  1  synchronous abort of the partial window.
- out_data  output  ACC_WIDTH  window sum at FIFO head.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts out_data.
- busy  output  1  partial window in progress (count != 0).

Behaviour:
- Reset (asynchronous, immediate):
  - acc=0, count=0, FIFO emptied (pointers=0, occupancy=0), state IDLE.
  - out_valid=0, busy=0, in_ready=1; out_data don't-care (drive 0).
- Accept: in_valid && in_ready at the clock edge.
- Per accepted sample, count != KERNEL_SIZE-1: acc <= acc + zero-extended in_data; count <= count+1.
- Per accepted sample, count == KERNEL_SIZE-1: the result acc + in_data is written into the FIFO, then acc <= 0 and count <= 0.
- Arithmetic: unsigned, modulo 2^ACC_WIDTH; no saturation, no overflow flag.
- in_ready = !(fifo_full && count == KERNEL_SIZE-1). It does not look at out_ready, so there is no combinational path from out_ready to in_ready.
- A pop in the same cycle does not free the slot for that cycle's push.
- States:
  - IDLE (count=0).
  - ACCUM (0 < count < KERNEL_SIZE-1, or count=KERNEL_SIZE-1 with FIFO not full).
  - STALL (count=KERNEL_SIZE-1 and FIFO full; in_ready=0).
- Transitions:
  - IDLE->ACCUM on accept.
  - ACCUM->IDLE on window-completing accept.
  - ACCUM->STALL when the FIFO fills while count=KERNEL_SIZE-1.
  - STALL->ACCUM on a pop.
  - Any state -> IDLE on clear or rst.
- busy = (count != 0).
- Output side:
  - out_valid = FIFO not empty; out_data = FIFO head.
  - Pop on out_valid && out_ready.
  - Results leave strictly in completion order.
  - out_data/out_valid hold stable while out_valid && !out_ready.
- Latency: window-completing accept at edge N -> out_valid=1 after edge N when the FIFO was empty (1 cycle).
- Simultaneous push and pop, FIFO non-full: both happen; occupancy unchanged.
- Simultaneous push and pop, FIFO empty: the push lands, the pop is ignored (out_valid was 0).
- clear:
  - Effect: acc<=0, count<=0. The sample presented with clear is discarded, even if in_valid=1.
  - in_ready is still driven normally in that cycle.
  - FIFO contents and the output handshake are unaffected.
- Reset mid-window or with the FIFO non-empty: all partial and buffered results are lost; the next accepted sample starts a fresh window.

Test Plan:
- Reset: hold rst=1 for 2 cycles, then release. Required: out_valid=0, busy=0, in_ready=1. Assert rst asynchronously mid-cycle; out_valid drops before the next edge.
- Single window: feed products 1..9 back-to-back with out_ready=1. Required: out_data=45 with out_valid=1 for exactly one cycle, the cycle after the 9th accept; busy=1 from the 1st to the 9th accept.
- Max value: nine samples of 65025 (255*255). Required: out_data=585225, no wrap at ACC_WIDTH=20.
- Backpressure:
  - Setup: out_ready=0; offer 5 windows of nine 1s with in_valid held high.
  - While stalled: 4 results buffered; in_ready=0 while the 9th sample of window 5 is pending; state STALL.
  - After out_ready=1: five results of 9 emerge in order, and in_ready rises after the first pop.
- Clear mid-window: accept 4 samples of 7, pulse clear with in_valid=1 and in_data=7, then send 9 samples of 2. Required: the single result is 18 (not 46); busy=0 the cycle after clear.
- Reset with data buffered: two results sitting in the FIFO plus a 3-sample partial window, assert rst. Required: out_valid=0 immediately. A following window of nine 3s yields 27 as the only output.
